// File: rtl/display_scan_driver.sv
// ============================================================================
// display_scan_driver: 4-digit multiplexed 7-segment scan with per-frame
// snapshot and blink-on-finished. Optional macro: LEADING_ZERO_BLANK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module display_scan_driver #(
  parameter int REFRESH_DIV = 4,
  parameter int BLINK_HALF  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] second_unit,
  input  logic [3:0] second_tens,
  input  logic [3:0] minute_unit,
  input  logic [3:0] minute_tens,
  input  logic       finished,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  phase_t           phase_q, phase_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;

  logic [15:0]      digits_w;
  logic [3:0]       cur_digit_w;
  logic             blank_w;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  assign digits_w = {minute_tens, minute_unit, second_tens, second_unit};

  always_comb begin
    cur_digit_w = snap_q[3:0];
    case (idx_q)
      2'd0:    cur_digit_w = snap_q[3:0];
      2'd1:    cur_digit_w = snap_q[7:4];
      2'd2:    cur_digit_w = snap_q[11:8];
      default: cur_digit_w = snap_q[15:12];
    endcase
  end

  always_comb begin
    blank_w = (phase_q == PH_OFF);
`ifdef LEADING_ZERO_BLANK_EN
    // Slot 3 still consumes its time; only its drive is suppressed.
    if ((idx_q == 2'd3) && (cur_digit_w == 4'd0)) begin
      blank_w = 1'b1;
    end
`endif
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    blink_d = blink_q;
    phase_d = phase_q;
    seg_d   = 7'd0;
    an_d    = 4'd0;
    dp_d    = 1'b0;

    if (!en) begin
      cnt_d   = '0;
      idx_d   = 2'd0;
      blink_d = '0;
      phase_d = PH_ON;
      snap_d  = digits_w;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
        // Snapshot only at frame wrap so a frame never mixes old and new digits.
        if (idx_q == 2'd3) begin
          snap_d = digits_w;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (finished) begin
        if (blink_q == BLK_LAST) begin
          blink_d = '0;
          phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
        end else begin
          blink_d = blink_q + BLK_W'(1);
        end
      end else begin
        blink_d = '0;
        phase_d = PH_ON;
      end

      if (!blank_w) begin
        seg_d = seg_decode(cur_digit_w);
        an_d  = 4'b0001 << idx_q;
        dp_d  = (idx_q == 2'd2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'd0;
      blink_q <= '0;
      phase_q <= PH_ON;
      seg_q   <= 7'd0;
      an_q    <= 4'd0;
      dp_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_driver.sv
// ============================================================================
// tb_display_scan_driver: scoreboard bench for display_scan_driver
// (REFRESH_DIV=4, BLINK_HALF=16). Rev 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_driver;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] su, st, mu, mt;
  logic       finished;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];

  display_scan_driver #(.REFRESH_DIV(4), .BLINK_HALF(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .second_unit (su),
    .second_tens (st),
    .minute_unit (mu),
    .minute_tens (mt),
    .finished    (finished),
    .seg         (seg),
    .an          (an),
    .dp          (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Expected {an, seg, dp} for one visible scan slot.
  function automatic logic [11:0] exp_slot(input int slot, input logic [3:0] d, input bit dark);
    logic [3:0] a;
    a = 4'b0001 << slot;
    if (dark) return 12'd0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3 && d == 4'd0) return 12'd0;
`endif
    return {a, seg_code(d), (slot == 2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] m10, input logic [3:0] m1,
                            input logic [3:0] s10, input logic [3:0] s1);
    mt = m10; mu = m1; st = s10; su = s1;
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
    logic [3:0] d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back(exp_slot(s, d[s], 1'b0));
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b0; en = 1'b0; finished = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    #2;
    got = {an, seg, dp};
    checks++;
    if (got !== 12'd0) begin
      failures++;
      $display("FAIL reset_initial got=%h want=000", got);
    end
    tick();
    got = {an, seg, dp};
    checks++;
    if (got !== 12'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h want=000", got);
    end
    rst = 1'b1;
  endtask

  task automatic test_static();
    logic [11:0] got, want;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    finished = 1'b0;
    restart();
    push_frame(4'd4, 4'd3, 4'd2, 4'd1);
    push_frame(4'd4, 4'd3, 4'd2, 4'd1);
    for (int i = 0; i < 32; i++) begin
      tick();
      got = {an, seg, dp};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL static cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_tear();
    logic [11:0] got, want;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    restart();
    push_frame(4'd4, 4'd3, 4'd2, 4'd1);
    push_frame(4'd8, 4'd7, 4'd6, 4'd5);
    for (int i = 0; i < 32; i++) begin
      tick();
      got = {an, seg, dp};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL tear cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
      if (i == 4) set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    end
  endtask

  task automatic test_blink();
    logic [11:0] got, want;
    bit dark;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    finished = 1'b1;
    restart();
    for (int e = 1; e <= 64; e++) begin
      dark = (e >= 17 && e <= 32) || (e >= 49 && e <= 53);
      exp_q.push_back(exp_slot(((e - 1) / 4) % 4, 4'd0, dark));
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      got = {an, seg, dp};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL blink edge=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i + 1, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
      if (i == 51) finished = 1'b0;
    end
  endtask

  task automatic test_invalid_and_enable();
    logic [11:0] got, want;
    set_digits(4'd0, 4'd0, 4'd0, 4'hA);
    finished = 1'b0;
    restart();
    for (int k = 0; k < 4; k++) exp_q.push_back({4'b0001, 7'b1000000, 1'b0});
    for (int k = 0; k < 2; k++) exp_q.push_back(exp_slot(1, 4'd0, 1'b0));
    exp_q.push_back(12'd0);
    exp_q.push_back(12'd0);
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_slot(0, 4'd9, 1'b0));
    exp_q.push_back(exp_slot(1, 4'd0, 1'b0));
    for (int i = 0; i < 13; i++) begin
      tick();
      got = {an, seg, dp};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL invalid_en cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
      if (i == 5) begin
        en = 1'b0;
        su = 4'd9;
      end
      if (i == 7) en = 1'b1;
    end
  endtask

  task automatic test_reset_midscan();
    logic [11:0] got, want;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    restart();
    push_frame(4'd4, 4'd3, 4'd2, 4'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      got = {an, seg, dp};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%h want=%h", i, got, want);
      end
    end
    exp_q.delete();
    rst = 1'b0;
    #2;
    got = {an, seg, dp};
    checks++;
    if (got !== 12'd0) begin
      failures++;
      $display("FAIL async_reset got=%h want=000", got);
    end
    tick();
    got = {an, seg, dp};
    checks++;
    if (got !== 12'd0) begin
      failures++;
      $display("FAIL reset_held got=%h want=000", got);
    end
    rst = 1'b1;
    // Snapshot is cleared by reset, so the first frame shows zeros.
    exp_q.push_back(exp_slot(0, 4'd0, 1'b0));
    tick();
    got = {an, seg, dp};
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL post_reset got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] got, want;
    set_digits(4'd0, 4'd5, 4'd0, 4'd9);
    restart();
    push_frame(4'd9, 4'd0, 4'd5, 4'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      got = {an, seg, dp};
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL lead_zero cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 i, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_tear();
    test_blink();
    test_invalid_and_enable();
    test_reset_midscan();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
